btn_key_encoder: RTL and testbench

Input front-end for the twelve-button colour panel. It synchronises and debounces the raw buttons `b1`..`b12` and detects press edges. Each press becomes a 4-bit key code held in a small FIFO and offered on a valid/ready interface to the LED/game logic. Presses are never silently lost: overload is flagged on a sticky overflow bit.

---
 rtl/btn_key_encoder_if.sv | 19 +
 rtl/btn_key_encoder.sv | 133 +++++++++++++
 tb/tb_btn_key_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_key_encoder_if.sv
// Key-code handshake between the button encoder and its consumer.
// The producer drives valid/code, the consumer answers with ready.
interface btn_key_encoder_if;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;

    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );
endinterface

// File: rtl/btn_key_encoder.sv
// Twelve-button front end: sync, debounce, press-edge detect,
// lowest-index arbitration into a small key FIFO.
module btn_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                b1,
    input  logic                b2,
    input  logic                b3,
    input  logic                b4,
    input  logic                b5,
    input  logic                b6,
    input  logic                b7,
    input  logic                b8,
    input  logic                b9,
    input  logic                b10,
    input  logic                b11,
    input  logic                b12,
    input  logic                ovf_clr,
    btn_key_encoder_if.master   key,
    output logic [11:0]         pressed,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [11:0]      raw;
    logic [11:0]      sync1;
    logic [11:0]      sync2;
    logic [11:0]      level;
    logic [11:0]      level_d;
    logic [CNT_W-1:0] cnt [12];
    logic [11:0]      pending;
    logic [11:0]      rise;
    logic [11:0]      grant;
    logic [11:0]      grant_eff;
    logic [11:0]      drop;
    logic [3:0]       gcode;
    logic [3:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign raw = {b12, b11, b10, b9, b8, b7,
                  b6, b5, b4, b3, b2, b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 12; i++) cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 12; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pressed = level;
    assign rise    = level & ~level_d;

    // Descending scan so the lowest pending index wins.
    always_comb begin
        grant = '0;
        gcode = '0;
        for (int i = 11; i >= 0; i--) begin
            if (pending[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                gcode    = 4'(i + 1);
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && key.key_ready;
    assign push  = (|pending) && (!full || pop);

    assign grant_eff = push ? grant : '0;
    assign drop      = rise & pending & ~grant_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~grant_eff) | rise;
            if (|drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= gcode;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign key.key_valid = !empty;
    assign key.key_code  = empty ? 4'd0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_btn_key_encoder.sv
// Scoreboard bench for btn_key_encoder with a short debounce
// window and a four-entry key FIFO.
module tb_btn_key_encoder;
    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic [11:0] b;
    logic        ovf_clr;
    logic [11:0] pressed;
    logic        overflow;
    int          tests;
    int          failed;
    logic [3:0]  sb [$];
    logic [3:0]  exp_code;

    btn_key_encoder_if kif ();

    btn_key_encoder #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]),
        .b5(b[4]), .b6(b[5]), .b7(b[6]), .b8(b[7]),
        .b9(b[8]), .b10(b[9]), .b11(b[10]), .b12(b[11]),
        .ovf_clr(ovf_clr),
        .key(kif.master),
        .pressed(pressed),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop side of the scoreboard: every accepted key is compared.
    always @(negedge clk) begin
        if (!rst && kif.key_valid && kif.key_ready) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL pop_unexpected: got code %0d, none expected",
                         kif.key_code);
            end else begin
                exp_code = sb.pop_front();
                if (kif.key_code !== exp_code) begin
                    failed++;
                    $display("FAIL pop_order: got %0d, want %0d",
                             kif.key_code, exp_code);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            step();
            k++;
        end
        step();
        tests++;
        if (sb.size() != 0 || kif.key_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s: left %0d, valid %b, want 0 and 0",
                     name, sb.size(), kif.key_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b = '0;
        ovf_clr = 1'b0;
        kif.key_ready = 1'b0;
        step(2);
        tests++;
        if ({kif.key_valid, kif.key_code, pressed, overflow} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: v=%b c=%0d p=%h o=%b, want all 0",
                     kif.key_valid, kif.key_code, pressed, overflow);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_press;
        b[4] = 1'b1;
        sb.push_back(4'd5);
        step(5);
        tests++;
        if (pressed[4] !== 1'b0) begin
            failed++;
            $display("FAIL press_early: pressed[4]=%b want 0", pressed[4]);
        end
        step();
        tests++;
        if (pressed[4] !== 1'b1) begin
            failed++;
            $display("FAIL press_level: pressed[4]=%b want 1", pressed[4]);
        end
        step();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            failed++;
            $display("FAIL valid_early: valid=%b want 0", kif.key_valid);
        end
        step();
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd5) begin
            failed++;
            $display("FAIL single_key: v=%b c=%0d want 1/5",
                     kif.key_valid, kif.key_code);
        end
        kif.key_ready = 1'b1;
        step();
        kif.key_ready = 1'b0;
        tests++;
        if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd0) begin
            failed++;
            $display("FAIL single_pop: v=%b c=%0d want 0/0",
                     kif.key_valid, kif.key_code);
        end
        b[4] = 1'b0;
        step(N + 3);
        tests++;
        if (pressed !== '0 || kif.key_valid !== 1'b0) begin
            failed++;
            $display("FAIL release: p=%h v=%b want 0/0",
                     pressed, kif.key_valid);
        end
    endtask

    task automatic test_glitch;
        b[2] = 1'b1;
        step(3);
        b[2] = 1'b0;
        step(12);
        tests++;
        if (pressed !== '0 || kif.key_valid !== 1'b0) begin
            failed++;
            $display("FAIL glitch_short: p=%h v=%b want 0/0",
                     pressed, kif.key_valid);
        end
        repeat (4) begin
            b[2] = 1'b1;
            step();
            b[2] = 1'b0;
            step();
        end
        tests++;
        if (pressed !== '0) begin
            failed++;
            $display("FAIL glitch_bounce: p=%h want 0", pressed);
        end
        b[2] = 1'b1;
        sb.push_back(4'd3);
        step(N + 8);
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd3) begin
            failed++;
            $display("FAIL bounce_key: v=%b c=%0d want 1/3",
                     kif.key_valid, kif.key_code);
        end
        kif.key_ready = 1'b1;
        wait_drain("bounce_single");
        kif.key_ready = 1'b0;
        b[2] = 1'b0;
        step(N + 3);
    endtask

    task automatic test_simultaneous;
        int k;
        kif.key_ready = 1'b1;
        b[11] = 1'b1;
        b[1]  = 1'b1;
        b[6]  = 1'b1;
        sb.push_back(4'd2);
        sb.push_back(4'd7);
        sb.push_back(4'd12);
        k = 0;
        while (kif.key_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        tests++;
        if (kif.key_code !== 4'd2) begin
            failed++;
            $display("FAIL simul_first: c=%0d want 2", kif.key_code);
        end
        step();
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd7) begin
            failed++;
            $display("FAIL simul_second: v=%b c=%0d want 1/7",
                     kif.key_valid, kif.key_code);
        end
        step();
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd12) begin
            failed++;
            $display("FAIL simul_third: v=%b c=%0d want 1/12",
                     kif.key_valid, kif.key_code);
        end
        wait_drain("simul_drain");
        tests++;
        if (overflow !== 1'b0) begin
            failed++;
            $display("FAIL simul_ovf: o=%b want 0", overflow);
        end
        kif.key_ready = 1'b0;
        b = '0;
        step(N + 3);
    endtask

    task automatic fill_five;
        for (int i = 0; i < 5; i++) begin
            b[i] = 1'b1;
            sb.push_back(4'(i + 1));
            step(N + 6);
        end
    endtask

    task automatic test_full_fifo;
        fill_five();
        tests++;
        if (kif.key_code !== 4'd1 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL full_head: c=%0d o=%b want 1/0",
                     kif.key_code, overflow);
        end
        b[4] = 1'b0;
        step(N + 4);
        b[4] = 1'b1;
        step(N + 4);
        tests++;
        if (overflow !== 1'b1) begin
            failed++;
            $display("FAIL overrun: o=%b want 1", overflow);
        end
        kif.key_ready = 1'b1;
        wait_drain("full_drain");
        kif.key_ready = 1'b0;
        tests++;
        if (overflow !== 1'b1) begin
            failed++;
            $display("FAIL ovf_sticky: o=%b want 1", overflow);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            failed++;
            $display("FAIL ovf_clr: o=%b want 0", overflow);
        end
        b = '0;
        step(N + 4);
    endtask

    task automatic test_back_to_back;
        fill_five();
        kif.key_ready = 1'b1;
        step();
        kif.key_ready = 1'b0;
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd2 ||
            overflow !== 1'b0) begin
            failed++;
            $display("FAIL pushpop_full: v=%b c=%0d o=%b want 1/2/0",
                     kif.key_valid, kif.key_code, overflow);
        end
        step(3);
        kif.key_ready = 1'b1;
        wait_drain("pushpop_drain");
        kif.key_ready = 1'b0;
        b = '0;
        step(N + 4);
    endtask

    task automatic test_reset_mid;
        int k;
        b[0] = 1'b1;
        step(N + 6);
        b[1] = 1'b1;
        step(N + 6);
        b[2] = 1'b1;
        k = 0;
        while (pressed[2] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        step();
        rst = 1'b1;
        #1;
        tests++;
        if (kif.key_valid !== 1'b0 || overflow !== 1'b0 ||
            pressed !== '0) begin
            failed++;
            $display("FAIL async_reset: v=%b o=%b p=%h want 0/0/0",
                     kif.key_valid, overflow, pressed);
        end
        sb.delete();
        b[2:1] = '0;
        step(2);
        rst = 1'b0;
        sb.push_back(4'd1);
        step(N + 6);
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd1) begin
            failed++;
            $display("FAIL held_repress: v=%b c=%0d want 1/1",
                     kif.key_valid, kif.key_code);
        end
        kif.key_ready = 1'b1;
        wait_drain("reset_stale");
        kif.key_ready = 1'b0;
        b = '0;
        step(N + 4);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_full_fifo();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
